// File: rtl/mips_trace_pkg.sv
// Shared types and constants for the MIPS data-memory write tracer.
// Default field widths here match the tracer's default parameters.
package mips_trace_pkg;

    localparam int TRACE_ADDR_W = 32;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_TS_W   = 16;

    localparam logic [15:0] OVF_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } tracer_state_e;

    typedef struct packed {
        logic [TRACE_TS_W-1:0]   ts;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/mips_memwrite_tracer_if.sv
// Store tap from the MEM stage plus the valid/ready drain port of the tracer.
// master = CPU tap and consumer side, slave = tracer side.
interface mips_memwrite_tracer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TS_W   = 16
);
    logic              memwrite;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;

    logic              rd_valid;
    logic              rd_ready;
    logic [TS_W-1:0]   rd_ts;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output memwrite, addr, wdata, rd_ready,
        input  rd_valid, rd_ts, rd_addr, rd_data
    );

    modport slave (
        input  memwrite, addr, wdata, rd_ready,
        output rd_valid, rd_ts, rd_addr, rd_data
    );
endinterface

// File: rtl/trace_fifo.sv
// Circular buffer of trace entries with push, pop and overwrite-oldest support.
// Reports whether each push was stored and whether it cost an entry.
module trace_fifo
    import mips_trace_pkg::*;
#(
    parameter int  DEPTH   = 16,
    parameter type entry_t = trace_entry_t
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     overwrite,
    input  entry_t                   wr_entry,
    output entry_t                   rd_entry,
    output logic                     written,
    output logic                     displaced,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wptr;
    logic [PTR_W-1:0]   rptr;
    logic               pop_ok;
    logic               do_push;
    logic               evict;
    logic               rd_adv;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A push while full is stored only if a pop frees the slot or the
    // oldest entry may be evicted; either way the head moves once.
    assign pop_ok    = pop && !empty;
    assign do_push   = push && (!full || pop_ok || overwrite);
    assign evict     = do_push && full && !pop_ok;
    assign rd_adv    = pop_ok || evict;
    assign written   = do_push;
    assign displaced = push && full && !pop_ok;
    assign rd_entry  = mem[rptr];

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + PTR_W'(1);
            if (rd_adv)  rptr <= rptr + PTR_W'(1);
            if (do_push && !rd_adv)
                count <= count + CNT_W'(1);
            else if (rd_adv && !do_push)
                count <= count - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the
    // pointers and count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wr_entry;
    end

endmodule

// File: rtl/mips_memwrite_tracer.sv
// Captures qualifying MEM-stage stores as {timestamp, address, data} entries
// and drains them through a valid/ready port.
module mips_memwrite_tracer
    import mips_trace_pkg::*;
#(
    parameter int ADDR_W = TRACE_ADDR_W,
    parameter int DATA_W = TRACE_DATA_W,
    parameter int DEPTH  = 16,
    parameter int TS_W   = TRACE_TS_W,
    parameter int LIM_W  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   cap_en,
    input  logic                   mode_wrap,
    input  logic [ADDR_W-1:0]      win_lo,
    input  logic [ADDR_W-1:0]      win_hi,
    input  logic [LIM_W-1:0]       stop_limit,
    mips_memwrite_tracer_if.slave  bus,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty,
    output logic [15:0]            overflow_cnt,
    output logic [1:0]             state
);
    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    tracer_state_e    state_q;
    tracer_state_e    state_d;
    logic [TS_W-1:0]  ts_q;
    logic [LIM_W-1:0] accepted_q;
    logic [LIM_W:0]   accepted_nxt;
    logic             in_window;
    logic             hit;
    logic             pop;
    logic             written;
    logic             displaced;
    logic             halt_hit;
    entry_t           wr_entry;
    entry_t           head;

    // An inverted window (win_lo > win_hi) can never satisfy both bounds.
    assign in_window = (bus.addr >= win_lo) && (bus.addr <= win_hi);
    assign hit       = (state_q == RUN) && bus.memwrite && in_window;
    assign pop       = !empty && bus.rd_ready;

    assign wr_entry.ts   = ts_q;
    assign wr_entry.addr = bus.addr;
    assign wr_entry.data = bus.wdata;

    assign accepted_nxt = {1'b0, accepted_q} + (LIM_W + 1)'(1);
    assign halt_hit     = written && (stop_limit != '0)
                          && (accepted_nxt >= {1'b0, stop_limit});

    trace_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .push      (hit),
        .pop       (pop),
        .overwrite (mode_wrap),
        .wr_entry  (wr_entry),
        .rd_entry  (head),
        .written   (written),
        .displaced (displaced),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    assign bus.rd_valid = !empty;
    assign bus.rd_ts    = empty ? '0 : head.ts;
    assign bus.rd_addr  = empty ? '0 : head.addr;
    assign bus.rd_data  = empty ? '0 : head.data;
    assign state        = state_q;

    // NOTE: next-state defaults to the current state before the case so no
    // path leaves state_d unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cap_en) state_d = RUN;
            RUN: begin
                if (halt_hit)     state_d = HALTED;
                else if (!cap_en) state_d = IDLE;
            end
            HALTED:  state_d = HALTED;
            default: state_d = IDLE;
        endcase
    end

    // Timestamp survives clear so traces across a flush stay comparable.
    always_ff @(posedge clk) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q      <= IDLE;
            accepted_q   <= '0;
            overflow_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (written && accepted_q != '1)
                accepted_q <= accepted_nxt[LIM_W-1:0];
            if (displaced && overflow_cnt != OVF_MAX)
                overflow_cnt <= overflow_cnt + 16'd1;
        end
    end

endmodule

// File: doc/mips_memwrite_tracer.md
Name: mips_memwrite_tracer

Overview:
Synthesizable, parametrised capture buffer for CPU data-memory writes; taps the MEM-stage signals (memwriteM, aluoutM, writedataM) of the MIPS core.
Records each qualifying store as a {timestamp, address, data} entry in an internal FIFO, filtered by an address window, with a selectable full-buffer policy and an optional capture limit.
Entries drain through a valid/ready read port, for a UART/debug bridge or a bench scoreboard. Replaces ad-hoc simulation-only write printing.

Parameters:
ADDR_W, 32, store address width
DATA_W, 32, store data width
DEPTH, 16, FIFO entries; power of 2, >= 2
TS_W, 16, free-running timestamp width
LIM_W, 8, capture-limit / accepted-count width

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
clear  in  1  synchronous flush: FIFO, overflow_cnt, accepted count, FSM
cap_en  in  1  capture enable
mode_wrap  in  1  0 = drop new entries when full; 1 = overwrite oldest
win_lo  in  ADDR_W  inclusive lower address bound
win_hi  in  ADDR_W  inclusive upper address bound
stop_limit  in  LIM_W  halt after this many accepted entries; 0 = unlimited
memwrite  in  1  store strobe (memwriteM)
addr  in  ADDR_W  store address (aluoutM)
wdata  in  DATA_W  store data (writedataM)
rd_valid  out  1  head entry available
rd_ready  in  1  consumer accepts head entry
rd_ts  out  TS_W  head timestamp
rd_addr  out  ADDR_W  head address
rd_data  out  DATA_W  head data
count  out  $clog2(DEPTH)+1  current occupancy
full  out  1  count == DEPTH
empty  out  1  count == 0
overflow_cnt  out  16  entries lost (dropped or overwritten); saturates at 0xFFFF
state  out  2  FSM state (IDLE=0, RUN=1, HALTED=2)

Behaviour:
- Reset (synchronous): FIFO empty; all outputs 0 except empty=1; overflow_cnt=0; timestamp=0; accepted=0; state=IDLE. Reset has priority over clear.
- clear: same as reset, except the timestamp keeps running.
- Timestamp: increments every non-reset cycle and wraps modulo 2^TS_W. An entry carries the timestamp value of the cycle in which its store is sampled.
- FSM:
  - IDLE -> RUN when cap_en=1.
  - RUN -> IDLE when cap_en=0.
  - RUN -> HALTED on the cycle the accepted count reaches stop_limit (stop_limit != 0).
  - HALTED exits only via clear or reset. cap_en is ignored in HALTED.
- Qualify (combinational): hit = state==RUN && memwrite && win_lo <= addr <= win_hi, unsigned compare. win_lo > win_hi means no hits.
- Push latency: a hit sampled at edge N appears at the read port from cycle N+1. No same-cycle bypass while empty.
- Pop: occurs when rd_valid && rd_ready at the clock edge. The rd_* outputs are stable while rd_valid=1 and rd_ready=0.
- Hit and pop in the same cycle, any occupancy including full: both happen; count is unchanged; no overflow.
- Hit while full with no pop:
  - mode_wrap=0: entry dropped; overflow_cnt+1; accepted unchanged.
  - mode_wrap=1: oldest entry discarded (read pointer advances); new entry written; overflow_cnt+1; accepted+1.
- Accepted counter: counts entries written to the FIFO; never wraps past stop_limit.
- Pointers: $clog2(DEPTH) bits, wrap modulo DEPTH. count tracks occupancy explicitly.
- Changing mode_wrap or the window mid-run takes effect from the next sampled store. No entry is corrupted.

Decomposition:
- Package mips_trace_pkg: tracer_state_e enum (IDLE, RUN, HALTED); trace_entry_t packed struct {ts, addr, data}, parametrised via package localparams matching the defaults; OVF_MAX constant.
- Sub-module trace_fifo: DEPTH x trace_entry_t storage with push, pop, overwrite, count, full, empty.
- Top-level mips_memwrite_tracer holds the timestamp counter, window qualify, FSM, accepted and overflow counters.

Test Plan:
- Reset, then cap_en=1, window 0x0-0xFF, stores to 0x54 (data 0x7) and 0x200 (data 0x9), rd_ready=1 -> exactly one entry {addr 0x54, data 0x7}; rd_valid rises the cycle after the store.
- DEPTH=16, mode_wrap=0, rd_ready=0, 20 stores of data 0..19 -> full=1, count=16, overflow_cnt=4; drain yields data 0..15 in order.
- Same as previous with mode_wrap=1 -> overflow_cnt=4; drain yields data 4..19.
- Fill to 16, then one cycle with a hit (data 0xAA) and rd_ready=1 -> count stays 16, overflow_cnt unchanged, last drained entry is 0xAA.
- stop_limit=3, 5 hits -> state=HALTED after the 3rd; count=3; further stores ignored even with cap_en toggling; clear -> state=IDLE, count=0.
- Reset asserted mid-drain with count=7 -> next cycle empty=1, rd_valid=0, overflow_cnt=0, state=IDLE.
